// File: rtl/lsu_mem_access_pkg.sv
`default_nettype none
// ============================================================================
// Module   : lsu_mem_access_pkg
// Brief    : Load/store type codes and FSM state encoding for the LS stage.
// Revision : 1.0 - initial release
// ============================================================================
package lsu_mem_access_pkg;

    // Bit 3 = store, bit 2 = unsigned load, bits [1:0] = size (0 B, 1 H, 2 W).
    localparam logic [3:0] c_ls_lb  = 4'd0;
    localparam logic [3:0] c_ls_lh  = 4'd1;
    localparam logic [3:0] c_ls_lw  = 4'd2;
    localparam logic [3:0] c_ls_lbu = 4'd4;
    localparam logic [3:0] c_ls_lhu = 4'd5;
    localparam logic [3:0] c_ls_sb  = 4'd8;
    localparam logic [3:0] c_ls_sh  = 4'd9;
    localparam logic [3:0] c_ls_sw  = 4'd10;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_DONE = 2'd3
    } lsu_state_t;

endpackage
`default_nettype wire

// File: rtl/lsu_mem_access_align.sv
`default_nettype none
// ============================================================================
// Module   : lsu_mem_access_align
// Brief    : Store lane placement/strobes, load extract/extend, misalign check.
// Revision : 1.0 - initial release
// ============================================================================
module lsu_mem_access_align
    import lsu_mem_access_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [3:0]          st_type,
    input  logic [1:0]          st_lane,
    input  logic [DATA_W-1:0]   st_data,
    input  logic [3:0]          ld_type,
    input  logic [1:0]          ld_lane,
    input  logic [DATA_W-1:0]   ld_word,
    output logic [DATA_W-1:0]   st_wdata,
    output logic [DATA_W/8-1:0] st_wstrb,
    output logic                st_we,
    output logic [DATA_W-1:0]   ld_data,
    output logic                misalign
);

    localparam int STRB_W = DATA_W / 8;

    logic [DATA_W-1:0] w_shifted;
    logic [7:0]        w_byte;
    logic [15:0]       w_half;
    logic [STRB_W-1:0] w_strb_b;
    logic [STRB_W-1:0] w_strb_h;

    assign w_shifted = ld_word >> {ld_lane, 3'b000};
    assign w_byte    = w_shifted[7:0];
    assign w_half    = w_shifted[15:0];
    assign w_strb_b  = {{(STRB_W-1){1'b0}}, 1'b1} << st_lane;
    assign w_strb_h  = {{(STRB_W-2){1'b0}}, 2'b11} << st_lane;
    assign st_we     = st_type[3];

    always_comb begin
        st_wdata = st_data;
        st_wstrb = '0;
        misalign = 1'b0;
        case (st_type[1:0])
            2'b00: begin
                st_wdata = {STRB_W{st_data[7:0]}};
                st_wstrb = w_strb_b;
            end
            2'b01: begin
                st_wdata = {(DATA_W/16){st_data[15:0]}};
                st_wstrb = w_strb_h;
                misalign = st_lane[0];
            end
            2'b10: begin
                st_wstrb = '1;
                misalign = (st_lane != 2'b00);
            end
            default: ;
        endcase
        if (!st_type[3]) begin
            st_wstrb = '0;
        end
    end

    always_comb begin
        ld_data = ld_word;
        case (ld_type)
            c_ls_lb:  ld_data = {{(DATA_W-8){w_byte[7]}}, w_byte};
            c_ls_lbu: ld_data = {{(DATA_W-8){1'b0}}, w_byte};
            c_ls_lh:  ld_data = {{(DATA_W-16){w_half[15]}}, w_half};
            c_ls_lhu: ld_data = {{(DATA_W-16){1'b0}}, w_half};
            default:  ld_data = ld_word;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/lsu_mem_access.sv
`default_nettype none
// ============================================================================
// Module   : lsu_mem_access
// Brief    : LS-stage load/store unit; one outstanding valid/ready access.
// Revision : 1.0 - initial release
// ============================================================================
module lsu_mem_access
    import lsu_mem_access_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                ls_valid_i,
    input  logic [3:0]          ls_type_i,
    input  logic [ADDR_W-1:0]   memory_addr_i,
    input  logic [DATA_W-1:0]   store_data_i,
    input  logic                flush_i,
    output logic                mem_req_valid_o,
    input  logic                mem_req_ready_i,
    output logic                mem_req_we_o,
    output logic [ADDR_W-1:0]   mem_req_addr_o,
    output logic [DATA_W-1:0]   mem_req_wdata_o,
    output logic [DATA_W/8-1:0] mem_req_wstrb_o,
    input  logic                mem_rsp_valid_i,
    input  logic [DATA_W-1:0]   mem_rsp_rdata_i,
    input  logic                mem_rsp_err_i,
    output logic                stall_req_o,
    output logic                lsu_done_o,
    output logic [DATA_W-1:0]   lsu_rdata_o,
    output logic                misalign_o,
    output logic                fault_o
);

    lsu_state_t          r_state;
    lsu_state_t          w_next;
    logic [3:0]          r_type;
    logic [1:0]          r_lane;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_wdata;
    logic [DATA_W/8-1:0] r_wstrb;
    logic                r_we;
    logic                r_drop;
    logic                r_err;
    logic [DATA_W-1:0]   r_rdata;

    logic [DATA_W-1:0]   w_st_wdata;
    logic [DATA_W/8-1:0] w_st_wstrb;
    logic                w_st_we;
    logic [DATA_W-1:0]   w_ld_data;
    logic                w_misalign;
    logic                w_start;

    lsu_mem_access_align #(.DATA_W(DATA_W)) u_align (
        .st_type  (ls_type_i),
        .st_lane  (memory_addr_i[1:0]),
        .st_data  (store_data_i),
        .ld_type  (r_type),
        .ld_lane  (r_lane),
        .ld_word  (mem_rsp_rdata_i),
        .st_wdata (w_st_wdata),
        .st_wstrb (w_st_wstrb),
        .st_we    (w_st_we),
        .ld_data  (w_ld_data),
        .misalign (w_misalign)
    );

    assign w_start = ls_valid_i && !w_misalign && !flush_i;

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_start)         w_next = S_REQ;
            S_REQ:   if (mem_req_ready_i) w_next = S_WAIT;
            S_WAIT:  if (mem_rsp_valid_i) w_next = S_DONE;
            S_DONE:                       w_next = S_IDLE;
            default:                      w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_type  <= '0;
            r_lane  <= '0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_wstrb <= '0;
            r_we    <= 1'b0;
            r_drop  <= 1'b0;
            r_err   <= 1'b0;
            r_rdata <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == S_IDLE && w_start) begin
                r_type  <= ls_type_i;
                r_lane  <= memory_addr_i[1:0];
                r_addr  <= {memory_addr_i[ADDR_W-1:2], 2'b00};
                r_wdata <= w_st_wdata;
                r_wstrb <= w_st_wstrb;
                r_we    <= w_st_we;
            end
            if ((r_state == S_REQ || r_state == S_WAIT) && flush_i) begin
                r_drop <= 1'b1;
            end
            // A flush arriving with the response is treated like an earlier one.
            if (r_state == S_WAIT && mem_rsp_valid_i) begin
                r_err <= mem_rsp_err_i;
                if (!r_we && !mem_rsp_err_i && !r_drop && !flush_i) begin
                    r_rdata <= w_ld_data;
                end
            end
            if (r_state == S_DONE) begin
                r_drop <= 1'b0;
                r_err  <= 1'b0;
            end
        end
    end

    assign mem_req_valid_o = (r_state == S_REQ);
    assign mem_req_we_o    = r_we;
    assign mem_req_addr_o  = r_addr;
    assign mem_req_wdata_o = r_wdata;
    assign mem_req_wstrb_o = r_wstrb;
    assign lsu_rdata_o     = r_rdata;

    assign stall_req_o = (r_state == S_IDLE && w_start) || (r_state == S_REQ) || (r_state == S_WAIT);
    assign misalign_o  = (r_state == S_IDLE) && ls_valid_i && w_misalign;
    assign lsu_done_o  = (r_state == S_DONE) && !r_err && !r_drop && !flush_i;
    assign fault_o     = (r_state == S_DONE) &&  r_err && !r_drop && !flush_i;

endmodule
`default_nettype wire

// File: tb/tb_lsu_mem_access.sv
`default_nettype none
// ============================================================================
// Module   : tb_lsu_mem_access
// Brief    : Directed vector bench for lsu_mem_access with a hand-driven bus.
// Revision : 1.0 - initial release
// ============================================================================
module tb_lsu_mem_access;
    import lsu_mem_access_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ls_valid_i = 1'b0;
    logic [3:0]  ls_type_i = '0;
    logic [31:0] memory_addr_i = '0;
    logic [31:0] store_data_i = '0;
    logic        flush_i = 1'b0;
    logic        mem_req_valid_o;
    logic        mem_req_ready_i = 1'b0;
    logic        mem_req_we_o;
    logic [31:0] mem_req_addr_o;
    logic [31:0] mem_req_wdata_o;
    logic [3:0]  mem_req_wstrb_o;
    logic        mem_rsp_valid_i = 1'b0;
    logic [31:0] mem_rsp_rdata_i = '0;
    logic        mem_rsp_err_i = 1'b0;
    logic        stall_req_o;
    logic        lsu_done_o;
    logic [31:0] lsu_rdata_o;
    logic        misalign_o;
    logic        fault_o;

    int checks   = 0;
    int failures = 0;
    logic [31:0] held = '0;

    lsu_mem_access #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .rst(rst),
        .ls_valid_i(ls_valid_i), .ls_type_i(ls_type_i),
        .memory_addr_i(memory_addr_i), .store_data_i(store_data_i),
        .flush_i(flush_i),
        .mem_req_valid_o(mem_req_valid_o), .mem_req_ready_i(mem_req_ready_i),
        .mem_req_we_o(mem_req_we_o), .mem_req_addr_o(mem_req_addr_o),
        .mem_req_wdata_o(mem_req_wdata_o), .mem_req_wstrb_o(mem_req_wstrb_o),
        .mem_rsp_valid_i(mem_rsp_valid_i), .mem_rsp_rdata_i(mem_rsp_rdata_i),
        .mem_rsp_err_i(mem_rsp_err_i),
        .stall_req_o(stall_req_o), .lsu_done_o(lsu_done_o),
        .lsu_rdata_o(lsu_rdata_o), .misalign_o(misalign_o), .fault_o(fault_o)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    typedef struct {
        logic [3:0]  typ;
        logic [31:0] addr;
        logic [31:0] sdata;
        logic [31:0] rdata;
        int          ready_dly;
        int          rsp_dly;
        bit          flush_wait;
        bit          err;
        bit          mis;
        logic [31:0] exp_addr;
        logic [31:0] exp_wdata;
        logic [3:0]  exp_wstrb;
        logic        exp_we;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs[16];

    function automatic vec_t mk(input logic [3:0] typ, input logic [31:0] addr, input logic [31:0] sdata,
                                input logic [31:0] rdata, input int rdy, input int rsp, input bit fl,
                                input bit er, input bit mis, input logic [31:0] ea, input logic [31:0] ew,
                                input logic [3:0] es, input logic ewe, input logic [31:0] er_data);
        vec_t v;
        v.typ = typ; v.addr = addr; v.sdata = sdata; v.rdata = rdata;
        v.ready_dly = rdy; v.rsp_dly = rsp; v.flush_wait = fl; v.err = er; v.mis = mis;
        v.exp_addr = ea; v.exp_wdata = ew; v.exp_wstrb = es; v.exp_we = ewe; v.exp_rdata = er_data;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        bit ok;
        tick();
        ls_valid_i = 1'b1; ls_type_i = v.typ; memory_addr_i = v.addr; store_data_i = v.sdata;
        @(negedge clk);
        chk($sformatf("v%0d misalign", idx), {31'b0, misalign_o}, {31'b0, v.mis});
        chk($sformatf("v%0d idle_stall", idx), {31'b0, stall_req_o}, {31'b0, !v.mis});
        if (v.mis) begin
            tick();
            @(negedge clk);
            chk($sformatf("v%0d mis_no_req", idx), {31'b0, mem_req_valid_o}, 32'd0);
            chk($sformatf("v%0d mis_no_stall", idx), {31'b0, stall_req_o}, 32'd0);
            tick();
            ls_valid_i = 1'b0;
            return;
        end
        tick();
        for (int i = 0; i <= v.ready_dly; i++) begin
            mem_req_ready_i = (i == v.ready_dly);
            @(negedge clk);
            chk($sformatf("v%0d req_valid c%0d", idx, i), {31'b0, mem_req_valid_o}, 32'd1);
            chk($sformatf("v%0d req_addr c%0d", idx, i), mem_req_addr_o, v.exp_addr);
            chk($sformatf("v%0d req_wdata c%0d", idx, i), mem_req_wdata_o, v.exp_wdata);
            chk($sformatf("v%0d req_wstrb c%0d", idx, i), {28'b0, mem_req_wstrb_o}, {28'b0, v.exp_wstrb});
            chk($sformatf("v%0d req_we c%0d", idx, i), {31'b0, mem_req_we_o}, {31'b0, v.exp_we});
            chk($sformatf("v%0d req_stall c%0d", idx, i), {31'b0, stall_req_o}, 32'd1);
            tick();
        end
        mem_req_ready_i = 1'b0;
        for (int i = 0; i <= v.rsp_dly; i++) begin
            if (v.flush_wait && i == 0) flush_i = 1'b1;
            if (i == v.rsp_dly) begin
                mem_rsp_valid_i = 1'b1; mem_rsp_rdata_i = v.rdata; mem_rsp_err_i = v.err;
            end
            @(negedge clk);
            chk($sformatf("v%0d wait_req_low c%0d", idx, i), {31'b0, mem_req_valid_o}, 32'd0);
            chk($sformatf("v%0d wait_stall c%0d", idx, i), {31'b0, stall_req_o}, 32'd1);
            tick();
            flush_i = 1'b0; mem_rsp_valid_i = 1'b0; mem_rsp_err_i = 1'b0;
        end
        ok = !v.err && !v.flush_wait;
        if (ok && !v.exp_we) held = v.exp_rdata;
        @(negedge clk);
        chk($sformatf("v%0d done", idx), {31'b0, lsu_done_o}, {31'b0, ok});
        chk($sformatf("v%0d fault", idx), {31'b0, fault_o}, {31'b0, v.err && !v.flush_wait});
        chk($sformatf("v%0d done_stall", idx), {31'b0, stall_req_o}, 32'd0);
        chk($sformatf("v%0d rdata", idx), lsu_rdata_o, held);
        tick();
        ls_valid_i = 1'b0;
        @(negedge clk);
        chk($sformatf("v%0d post_idle_no_req", idx), {31'b0, mem_req_valid_o}, 32'd0);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, " req_valid"}, {31'b0, mem_req_valid_o}, 32'd0);
        chk({tag, " we"}, {31'b0, mem_req_we_o}, 32'd0);
        chk({tag, " addr"}, mem_req_addr_o, 32'd0);
        chk({tag, " wdata"}, mem_req_wdata_o, 32'd0);
        chk({tag, " wstrb"}, {28'b0, mem_req_wstrb_o}, 32'd0);
        chk({tag, " stall"}, {31'b0, stall_req_o}, 32'd0);
        chk({tag, " done"}, {31'b0, lsu_done_o}, 32'd0);
        chk({tag, " fault"}, {31'b0, fault_o}, 32'd0);
        chk({tag, " misalign"}, {31'b0, misalign_o}, 32'd0);
        chk({tag, " rdata"}, lsu_rdata_o, 32'd0);
    endtask

    initial begin
        //                 type      addr          sdata         rdata       rdy rsp fl er mis exp_addr      exp_wdata     strb  we exp_rdata
        vecs[0]  = mk(c_ls_lw,  32'h8000_0010, 32'h0,         32'hDEAD_BEEF, 0, 0, 0, 0, 0, 32'h8000_0010, 32'h0,         4'h0, 0, 32'hDEAD_BEEF);
        vecs[1]  = mk(c_ls_lb,  32'h8000_0003, 32'h0,         32'h8012_3456, 0, 0, 0, 0, 0, 32'h8000_0000, 32'h0,         4'h0, 0, 32'hFFFF_FF80);
        vecs[2]  = mk(c_ls_lbu, 32'h8000_0003, 32'h0,         32'h8012_3456, 0, 0, 0, 0, 0, 32'h8000_0000, 32'h0,         4'h0, 0, 32'h0000_0080);
        vecs[3]  = mk(c_ls_lhu, 32'h8000_0002, 32'h0,         32'hBEEF_1234, 0, 0, 0, 0, 0, 32'h8000_0000, 32'h0,         4'h0, 0, 32'h0000_BEEF);
        vecs[4]  = mk(c_ls_lh,  32'h8000_0002, 32'h0,         32'hBEEF_1234, 0, 0, 0, 0, 0, 32'h8000_0000, 32'h0,         4'h0, 0, 32'hFFFF_BEEF);
        vecs[5]  = mk(c_ls_lb,  32'h8000_0001, 32'h0,         32'h1234_7F56, 0, 0, 0, 0, 0, 32'h8000_0000, 32'h0,         4'h0, 0, 32'h0000_007F);
        vecs[6]  = mk(c_ls_sb,  32'h8000_0021, 32'h0000_00A5, 32'h0,         0, 0, 0, 0, 0, 32'h8000_0020, 32'hA5A5_A5A5, 4'h2, 1, 32'h0);
        vecs[7]  = mk(c_ls_sw,  32'h8000_0040, 32'hCAFE_F00D, 32'h0,         0, 0, 0, 0, 0, 32'h8000_0040, 32'hCAFE_F00D, 4'hF, 1, 32'h0);
        vecs[8]  = mk(c_ls_sh,  32'h8000_0002, 32'h1234_ABCD, 32'h0,         3, 0, 0, 0, 0, 32'h8000_0000, 32'hABCD_ABCD, 4'hC, 1, 32'h0);
        vecs[9]  = mk(c_ls_lw,  32'h8000_0001, 32'h0,         32'h0,         0, 0, 0, 0, 1, 32'h0,         32'h0,         4'h0, 0, 32'h0);
        vecs[10] = mk(c_ls_lh,  32'h8000_0003, 32'h0,         32'h0,         0, 0, 0, 0, 1, 32'h0,         32'h0,         4'h0, 0, 32'h0);
        vecs[11] = mk(c_ls_sw,  32'h8000_0006, 32'h0,         32'h0,         0, 0, 0, 0, 1, 32'h0,         32'h0,         4'h0, 0, 32'h0);
        vecs[12] = mk(c_ls_lhu, 32'h8000_0000, 32'h0,         32'h0000_8001, 0, 2, 0, 0, 0, 32'h8000_0000, 32'h0,         4'h0, 0, 32'h0000_8001);
        vecs[13] = mk(c_ls_lw,  32'h8000_0004, 32'h0,         32'h1111_1111, 0, 1, 1, 0, 0, 32'h8000_0004, 32'h0,         4'h0, 0, 32'h1111_1111);
        vecs[14] = mk(c_ls_lw,  32'h8000_0008, 32'h0,         32'h2222_2222, 1, 0, 0, 0, 0, 32'h8000_0008, 32'h0,         4'h0, 0, 32'h2222_2222);
        vecs[15] = mk(c_ls_sw,  32'h8000_000C, 32'h5A5A_5A5A, 32'h0,         0, 0, 0, 1, 0, 32'h8000_000C, 32'h5A5A_5A5A, 4'hF, 1, 32'h0);

        repeat (3) tick();
        rst = 1'b0;
        @(negedge clk);
        chk_all_zero("reset");

        for (int i = 0; i < 16; i++) run_vec(vecs[i], i);

        // Flush while an op is presented in IDLE must not start it.
        tick();
        ls_valid_i = 1'b1; ls_type_i = c_ls_lw; memory_addr_i = 32'h8000_0200; flush_i = 1'b1;
        @(negedge clk);
        chk("idle_flush stall", {31'b0, stall_req_o}, 32'd0);
        tick();
        @(negedge clk);
        chk("idle_flush no_req", {31'b0, mem_req_valid_o}, 32'd0);
        tick();
        ls_valid_i = 1'b0; flush_i = 1'b0;

        // Reset while a request is waiting for ready.
        tick();
        ls_valid_i = 1'b1; ls_type_i = c_ls_sw; memory_addr_i = 32'h8000_0100; store_data_i = 32'h0BAD_F00D;
        tick();
        @(negedge clk);
        chk("rst_req req_valid_before", {31'b0, mem_req_valid_o}, 32'd1);
        chk("rst_req rdata_before", lsu_rdata_o, 32'h2222_2222);
        tick();
        rst = 1'b1; ls_valid_i = 1'b0;
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk_all_zero("rst_req");
        held = '0;

        run_vec(vecs[0], 100);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/lsu_mem_access.md
# lsu_mem_access

Load/store execution unit of the NPC LS stage. Consumes the memory operation held in the EX/LS pipeline register (valid flag, type, address, store data), issues one word-wide request on the data-memory valid/ready bus, and waits for the response. It sign- or zero-extends load data and raises a stall request that freezes EX/LS and upstream until the access completes. Its result feeds the LS/WB register.

## Interface
Parameters:
- `ADDR_W`, 32, address width.
- `DATA_W`, 32, data width; `DATA_W/8` strobe bits.

Ports:
- `clk`  in  1  single clock domain, rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `ls_valid_i`  in  1  EX/LS holds a load/store.
- `ls_type_i`  in  4  operation code: LB, LH, LW, LBU, LHU, SB, SH, SW.
- `memory_addr_i`  in  ADDR_W  byte address.
- `store_data_i`  in  DATA_W  store data, right-aligned.
- `flush_i`  in  1  pipeline flush (exception/redirect).
- `mem_req_valid_o`  out  1  request valid.
- `mem_req_ready_i`  in  1  memory accepts request.
- `mem_req_we_o`  out  1  1 = store.
- `mem_req_addr_o`  out  ADDR_W  word-aligned address (`[1:0]`=0).
- `mem_req_wdata_o`  out  DATA_W  lane-positioned store data.
- `mem_req_wstrb_o`  out  DATA_W/8  byte strobes; 0 for loads.
- `mem_rsp_valid_i`  in  1  response/ack, one cycle.
- `mem_rsp_rdata_i`  in  DATA_W  read word.
- `mem_rsp_err_i`  in  1  access fault, qualified by `mem_rsp_valid_i`.
- `stall_req_o`  out  1  hold EX/LS (drives `Stall_ex_ls` request).
- `lsu_done_o`  out  1  one-cycle pulse: access completed OK.
- `lsu_rdata_o`  out  DATA_W  extended load result, valid with `lsu_done_o`, held until the next load completes.
- `misalign_o`  out  1  combinational: misaligned access presented in IDLE.
- `fault_o`  out  1  one-cycle pulse: bus error response.

## Operation
- FSM states are IDLE, REQ, WAIT and DONE.
- IDLE: if `ls_valid_i` and the access is aligned and `!flush_i`, capture type, lane `addr[1:0]`, word address, wdata and wstrb, then go to REQ.
  - Misaligned access (H with `addr[0]`=1; W with `addr[1:0]`≠0): `misalign_o`=1, no request, no stall, stay in IDLE.
- REQ: `mem_req_valid_o`=1 with a stable payload until `mem_req_ready_i`. On handshake, go to WAIT.
- WAIT: on `mem_rsp_valid_i`, capture the extended data (loads) and the err flag, then go to DONE. The response is never taken in the handshake cycle.
- DONE: pulse `lsu_done_o` (err=0) or `fault_o` (err=1), then go to IDLE unconditionally. EX/LS still shows the same op this cycle and must not restart.
- `stall_req_o` = (IDLE ∧ valid ∧ aligned ∧ !flush_i) ∨ REQ ∨ WAIT. It is 0 in DONE, so the pipeline advances at the end of DONE.
- Store lane rules:
  - SB: wdata is byte ×4, wstrb `1<<lane`.
  - SH: wdata is half ×2, wstrb `3<<lane`.
  - SW: wstrb `4'hF`.
- Load extension selects byte `rdata[8*lane+:8]` or half `rdata[8*lane+:16]`. LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word.
- Flush in REQ or WAIT sets a drop flag. The request stays valid until handshake (bus rule) and the response is still consumed. In DONE, both `lsu_done_o` and `fault_o` are suppressed and `lsu_rdata_o` is not updated. The flag clears on return to IDLE.
- Flush in DONE suppresses that cycle's pulses.
- Reset (any state, synchronous) forces IDLE, clears the drop flag and sets all outputs to 0, including `lsu_rdata_o`.
  - An outstanding bus transaction is abandoned; the memory model is reset by the same `rst`.

## Timing
- Zero-wait memory (ready in the first REQ cycle, response the next cycle): IDLE at c0, REQ at c1, WAIT at c2 with response, DONE at c3. Four cycles total; `stall_req_o` is high c0–c2.
- Each cycle of ready low adds one REQ cycle; each cycle of response delay adds one WAIT cycle.
- Request outputs are registered. `stall_req_o` and `misalign_o` are combinational from the inputs and state.
- At most one transaction is outstanding; a back-to-back op is re-sampled in IDLE the cycle after DONE.

## Structure
- Add to shared `defines.v`: ls type codes LB=0, LH=1, LW=2, LBU=4, LHU=5, SB=8, SH=9, SW=10; `ls_diff_bus` = [3:0]; FSM state encodings.
- Sub-module `lsu_align`: purely combinational. Store lane shift and strobe generation, load extract/extend, misalign detect.

## Test plan
- LW at 0x8000_0010, zero-wait, rdata 0xDEAD_BEEF: stall high 3 cycles, addr 0x8000_0010, wstrb 0, `lsu_rdata_o`=0xDEAD_BEEF, done at c3.
- LB at 0x…03 with rdata 0x80xx_xxxx gives 0xFFFF_FF80; LBU gives 0x0000_0080; LHU at 0x…02 with rdata 0xBEEF_xxxx gives 0x0000_BEEF.
- SH at 0x…02 with data 0x1234_ABCD: wdata 0xABCD_ABCD, wstrb 4'b1100, we=1. Ready held low 3 cycles: payload stable, stall held.
- LW at 0x…01: `misalign_o`=1, no `mem_req_valid_o`, stall 0.
- Flush asserted in WAIT: response consumed, no `lsu_done_o`, `lsu_rdata_o` unchanged. The next op issues normally.
- Error response on SW gives a `fault_o` pulse with no done. `rst` asserted in REQ gives IDLE next cycle with all outputs 0.
